// File: rtl/pc_if.sv
// Fetch-side bundle between the PC unit and instruction memory / pipeline control.
// master = PC unit, slave = the consumer of fetch requests.
interface pc_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             stall;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_target;
   logic             pc_ready;
   logic [WIDTH-1:0] pc;
   logic             pc_valid;
   logic [WIDTH-1:0] pc_plus;
   logic             misalign;
   logic [WIDTH-1:0] bad_addr;
   logic [CNT_W-1:0] fetch_cnt;

   modport master (
      input  stall, redirect_valid, redirect_target, pc_ready,
      output pc, pc_valid, pc_plus, misalign, bad_addr, fetch_cnt
   );
   modport slave (
      output stall, redirect_valid, redirect_target, pc_ready,
      input  pc, pc_valid, pc_plus, misalign, bad_addr, fetch_cnt
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with fetch handshake, redirect priority and misaligned-target trap.
// BOOT lasts one edge after reset; TRAP is left only by an aligned redirect.
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter int               INC       = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               CNT_W     = 16
) (
   input logic   clk,
   input logic   rst_n,
   pc_if.master  bus
);
   typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

   state_t           state;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] bad_q;
   logic             mis_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             aligned;

   assign bus.pc_valid  = (state == RUN) && !bus.stall;
   assign bus.pc_plus   = pc_q + WIDTH'(INC);
   assign bus.pc        = pc_q;
   assign bus.misalign  = mis_q;
   assign bus.bad_addr  = bad_q;
   assign bus.fetch_cnt = cnt_q;

   assign accept  = bus.pc_valid && bus.pc_ready;
   // mask of the low alignment bits; zero when INC==1, so every target is aligned
   assign aligned = (bus.redirect_target & WIDTH'(INC - 1)) == '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc_q  <= RESET_VEC;
         bad_q <= '0;
         mis_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (accept)
            cnt_q <= cnt_q + CNT_W'(1);
         if (bus.redirect_valid) begin
            if (aligned) begin
               pc_q  <= bus.redirect_target;
               state <= RUN;
               mis_q <= 1'b0;
            end else begin
               state <= TRAP;
               mis_q <= 1'b1;
               bad_q <= bus.redirect_target;
            end
         end else begin
            case (state)
               BOOT:    state <= RUN;
               RUN:     if (accept) pc_q <= bus.pc_plus;
               TRAP:    state <= TRAP;
               default: state <= BOOT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a cycle model checked every negedge plus literal spot checks.
module tb_pc_unit;
   localparam int WIDTH = 32;
   localparam int INC   = 4;
   localparam int CNT_W = 16;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   bit   chk_on = 0;

   pc_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   pc_unit #(.WIDTH(WIDTH), .INC(INC), .RESET_VEC('0), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: booting / trapped flags, plain modular arithmetic
   logic [WIDTH-1:0] m_pc, m_bad;
   logic [CNT_W-1:0] m_cnt;
   bit               m_boot, m_trap, m_mis;

   function automatic bit m_valid();
      return rst_n && !m_boot && !m_trap && !bus.stall;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= '0; m_bad <= '0; m_cnt <= '0;
         m_boot <= 1; m_trap <= 0; m_mis <= 0;
      end else begin
         if (m_valid() && bus.pc_ready) m_cnt <= m_cnt + 1;
         m_boot <= 0;
         if (bus.redirect_valid) begin
            if ((bus.redirect_target % INC) == 0) begin
               m_pc <= bus.redirect_target; m_trap <= 0; m_mis <= 0;
            end else begin
               m_trap <= 1; m_mis <= 1; m_bad <= bus.redirect_target;
            end
         end else if (m_valid() && bus.pc_ready) begin
            m_pc <= m_pc + INC;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_pc",        bus.pc,        m_pc);
         chk("m_pc_valid",  bus.pc_valid,  m_valid());
         chk("m_pc_plus",   bus.pc_plus,   WIDTH'(m_pc + INC));
         chk("m_misalign",  bus.misalign,  m_mis);
         chk("m_bad_addr",  bus.bad_addr,  m_bad);
         chk("m_fetch_cnt", bus.fetch_cnt, m_cnt);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic redir(input logic v, input logic [WIDTH-1:0] t);
      bus.redirect_valid  = v;
      bus.redirect_target = t;
   endtask

   typedef struct { bit s; bit r; bit v; logic [31:0] t; } vec_t;
   vec_t tbl[7];

   initial begin
      rst_n = 0;
      bus.stall = 0; bus.pc_ready = 1;
      redir(0, '0);
      #12;
      chk("rst_pc",       bus.pc,        0);
      chk("rst_pc_valid", bus.pc_valid,  0);
      chk("rst_misalign", bus.misalign,  0);
      chk("rst_bad_addr", bus.bad_addr,  0);
      chk("rst_cnt",      bus.fetch_cnt, 0);
      chk_on = 1;
      @(posedge clk); #2;
      rst_n = 1;
      #1;
      chk("boot_valid", bus.pc_valid, 0);
      chk("boot_pc",    bus.pc,       0);
      step(1);
      chk("run_valid", bus.pc_valid, 1);
      chk("run_pc0",   bus.pc,       0);
      step(3);
      chk("adv_pc",  bus.pc,        32'h0C);
      chk("adv_cnt", bus.fetch_cnt, 3);
      // backpressure then stall
      bus.pc_ready = 0;
      step(3);
      chk("hold_pc",    bus.pc,        32'h0C);
      chk("hold_valid", bus.pc_valid,  1);
      chk("hold_cnt",   bus.fetch_cnt, 3);
      bus.stall = 1; bus.pc_ready = 1;
      #1;
      chk("stall_valid", bus.pc_valid, 0);
      step(1);
      chk("stall_pc", bus.pc, 32'h0C);
      // redirect wins over coincident accept
      bus.stall = 0;
      redir(1, 32'h100);
      step(1);
      chk("redir_pc",  bus.pc,        32'h100);
      chk("redir_cnt", bus.fetch_cnt, 4);
      redir(1, 32'h102);
      step(1);
      chk("trap_mis",   bus.misalign, 1);
      chk("trap_bad",   bus.bad_addr, 32'h102);
      chk("trap_valid", bus.pc_valid, 0);
      chk("trap_pc",    bus.pc,       32'h100);
      redir(0, '0);
      step(1);
      chk("trap_hold_mis", bus.misalign, 1);
      redir(1, 32'h203);
      step(1);
      chk("trap_bad2", bus.bad_addr, 32'h203);
      chk("trap_cnt",  bus.fetch_cnt, 5);
      redir(1, 32'h200);
      step(1);
      chk("exit_pc",    bus.pc,       32'h200);
      chk("exit_mis",   bus.misalign, 0);
      chk("exit_valid", bus.pc_valid, 1);
      // wrap
      redir(1, 32'hFFFF_FFFC);
      step(1);
      chk("wrap_plus", bus.pc_plus, 0);
      redir(0, '0);
      step(1);
      chk("wrap_pc", bus.pc, 0);
      // mixed patterns, model-checked every cycle
      tbl = '{'{0,0,0,0}, '{1,1,0,0}, '{0,1,0,0}, '{1,1,1,32'h80},
              '{0,1,0,0}, '{0,0,1,32'h90}, '{0,1,0,0}};
      foreach (tbl[i]) begin
         bus.stall = tbl[i].s; bus.pc_ready = tbl[i].r;
         redir(tbl[i].v, tbl[i].t);
         step(1);
      end
      redir(0, '0); bus.stall = 0; bus.pc_ready = 1;
      step(1);
      // async reset mid-cycle
      rst_n = 0;
      #1;
      chk("mid_rst_pc",    bus.pc,        0);
      chk("mid_rst_valid", bus.pc_valid,  0);
      chk("mid_rst_cnt",   bus.fetch_cnt, 0);
      // redirect taken while in BOOT
      step(1);
      redir(1, 32'h40);
      rst_n = 1;
      step(1);
      chk("boot_redir_pc",  bus.pc,        32'h40);
      chk("boot_redir_cnt", bus.fetch_cnt, 0);
      // reset out of TRAP
      redir(1, 32'h41);
      step(1);
      chk("trap2_mis", bus.misalign, 1);
      redir(0, '0);
      step(1);
      rst_n = 0;
      #1;
      chk("trap_rst_mis", bus.misalign, 0);
      chk("trap_rst_bad", bus.bad_addr, 0);
      step(1);
      rst_n = 1;
      step(3);
      chk_on = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: address width in bits.
REQ-002 Parameter INC, default 4: byte increment per fetch; power of two, 1..16; alignment bits AB = log2(INC).
REQ-003 Parameter RESET_VEC, default 0: PC value loaded by reset; SHALL be INC-aligned.
REQ-004 Parameter CNT_W, default 16: fetch counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 stall  in  1  pipeline hold; suppresses fetch request.
REQ-008 redirect_valid  in  1  branch/jump/trap redirect strobe.
REQ-009 redirect_target  in  WIDTH  redirect byte address.
REQ-010 pc_ready  in  1  instruction memory accepts the current pc.
REQ-011 pc  out  WIDTH  current fetch byte address.
REQ-012 pc_valid  out  1  fetch request valid.
REQ-013 pc_plus  out  WIDTH  pc + INC, combinational, modulo 2^WIDTH.
REQ-014 misalign  out  1  misaligned redirect trap flag.
REQ-015 bad_addr  out  WIDTH  last misaligned redirect target.
REQ-016 fetch_cnt  out  CNT_W  accepted-fetch count.

Function
REQ-017 FSM states BOOT, RUN, TRAP; exactly one active.
REQ-018 BOOT: entered by reset; lasts exactly one clk edge after rst_n deasserts, then RUN unconditionally (unless redirect per REQ-024).
REQ-019 pc_valid SHALL equal (state==RUN) && !stall, combinational.
REQ-020 Handshake: fetch accepted on a rising edge with pc_valid && pc_ready.
REQ-021 Accepted fetch, no redirect: pc <= pc_plus; wrap from 2^WIDTH-INC to 0 with no flag.
REQ-022 pc_valid && !pc_ready, no redirect: pc, state held; pc stable until acceptance or redirect.
REQ-023 stall may withdraw pc_valid at any cycle; pc held while stall=1 and no redirect.
REQ-024 redirect_valid has priority over advance and stall, honoured in every state including BOOT.
REQ-025 Aligned redirect (target[AB-1:0]==0): pc <= redirect_target; state <= RUN; misalign <= 0.
REQ-026 Misaligned redirect: pc unchanged; state <= TRAP; misalign <= 1; bad_addr <= redirect_target.
REQ-027 TRAP: pc_valid=0; misalign held 1; exit only via aligned redirect; further misaligned redirects stay in TRAP and update bad_addr.
REQ-028 fetch_cnt increments by 1 on every accepted fetch, including one coincident with a redirect; wraps to 0 at 2^CNT_W.
REQ-029 INC=1: AB=0, no redirect is misaligned, TRAP unreachable.

Reset
REQ-030 rst_n low SHALL immediately, without clk: state=BOOT, pc=RESET_VEC, pc_valid=0, misalign=0, bad_addr=0, fetch_cnt=0.
REQ-031 Reset mid-fetch or in TRAP discards all in-flight state; no output glitch beyond REQ-030 values.

Verification (WIDTH=32, INC=4, RESET_VEC=0, CNT_W=16)
REQ-032 Release rst_n, pc_ready=1, stall=0 -> one cycle pc=0 pc_valid=0, then pc_valid=1; 3 edges later pc=0x0C, fetch_cnt=3.
REQ-033 pc=0x0C, pc_ready=0 for 3 cycles -> pc stays 0x0C, pc_valid=1, fetch_cnt=3; stall=1 one cycle -> pc_valid=0, pc 0x0C.
REQ-034 redirect_valid=1, target 0x100, pc_ready=1 same cycle -> next pc=0x100 (not 0x10), fetch_cnt +1.
REQ-035 Redirect target 0x102 -> TRAP, misalign=1, bad_addr=0x102, pc_valid=0, pc unchanged; then redirect 0x200 -> RUN, pc=0x200, misalign=0.
REQ-036 Redirect 0xFFFFFFFC, pc_plus=0; accept -> pc=0x00000000; rst_n low mid-run -> pc=0, pc_valid=0, fetch_cnt=0 before next clk edge.
